// File: rtl/supervisor_pkg.sv
// Shared definitions for the pump supervisor: state encodings and timer width.
package supervisor_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    VERIFICA  = 2'b01,
    BOMBEANDO = 2'b10,
    FALHA     = 2'b11
  } estado_t;

endpackage

// File: rtl/supervisor_bomba_if.sv
// Board-side signal bundle of the pump supervisor: sensor switches, buttons, LEDs and status.
interface supervisor_bomba_if;

  logic [2:0] chaves_sensores;
  logic       liga;
  logic       desliga;
  logic       reconhece;
  logic       led9;
  logic       led8;
  logic       led7;
  logic       bomba;
  logic       erro_sensor;
  logic       fim_ciclo;
  logic [1:0] estado;
  logic [7:0] contador_falhas;

  modport master (
    output chaves_sensores, liga, desliga, reconhece,
    input  led9, led8, led7, bomba, erro_sensor, fim_ciclo, estado, contador_falhas
  );

  modport slave (
    input  chaves_sensores, liga, desliga, reconhece,
    output led9, led8, led7, bomba, erro_sensor, fim_ciclo, estado, contador_falhas
  );

endinterface

// File: rtl/filtro_chave.sv
// One-bit debounce: the filtered level follows the raw level only after it has
// disagreed for DEBOUNCE_CICLOS consecutive cycles.
module filtro_chave #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bruto,
  output logic filtrado
);

  localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS - 1);

  logic [7:0] cnt_reg;
  logic       filt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (bruto == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LIMITE) begin
      filt_reg <= bruto;
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign filtrado = filt_reg;

endmodule

// File: rtl/supervisor_bomba.sv
// Pump sequencing supervisor: debounced sensors, start/verify/pump/fault FSM,
// state timer and saturating fault counter. All outputs come from registers.
module supervisor_bomba
  import supervisor_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TEMPO_VERIFICA  = 8,
  parameter int TEMPO_MAX_BOMBA = 200
) (
  input logic               clk,
  input logic               rst_n,
  supervisor_bomba_if.slave bus
);

  localparam logic [TIMER_W-1:0] FIM_VERIFICA = TIMER_W'(TEMPO_VERIFICA - 1);
  localparam logic [TIMER_W-1:0] FIM_BOMBA    = TIMER_W'(TEMPO_MAX_BOMBA - 1);

  logic [2:0]         sens_filt;
  logic               sensores_ok;
  estado_t            state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               fim_next;
  logic               entra_falha;
  logic               bomba_reg, erro_reg, fim_reg;
  logic [7:0]         falhas_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_filtro
    filtro_chave #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro (
      .clk     (clk),
      .rst_n   (rst_n),
      .bruto   (bus.chaves_sensores[gi]),
      .filtrado(sens_filt[gi])
    );
  end

  assign sensores_ok = &sens_filt;

  // Priority everywhere: sensor fault, then desliga, then liga / timeout.
  always_comb begin
    state_next = state_reg;
    fim_next   = 1'b0;
    unique case (state_reg)
      OCIOSO: begin
        if (!bus.desliga && bus.liga) state_next = VERIFICA;
      end
      VERIFICA: begin
        if (!sensores_ok)                 state_next = FALHA;
        else if (bus.desliga)             state_next = OCIOSO;
        else if (timer_reg == FIM_VERIFICA) state_next = BOMBEANDO;
      end
      BOMBEANDO: begin
        if (!sensores_ok)      state_next = FALHA;
        else if (bus.desliga)  state_next = OCIOSO;
        else if (timer_reg == FIM_BOMBA) begin
          state_next = OCIOSO;
          fim_next   = 1'b1;
        end
      end
      FALHA: begin
        if (bus.reconhece && sensores_ok) state_next = OCIOSO;
      end
      default: state_next = OCIOSO;
    endcase
  end

  assign timer_next  = (state_next != state_reg) ? '0 : timer_reg + 1'b1;
  assign entra_falha = (state_next == FALHA) && (state_reg != FALHA);

  // Status flags are computed from state_next so they line up with estado.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= OCIOSO;
      timer_reg  <= '0;
      bomba_reg  <= 1'b0;
      erro_reg   <= 1'b0;
      fim_reg    <= 1'b0;
      falhas_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      bomba_reg <= (state_next == BOMBEANDO);
      erro_reg  <= (state_next == FALHA);
      fim_reg   <= fim_next;
      if (entra_falha && (falhas_reg != 8'hFF)) falhas_reg <= falhas_reg + 8'd1;
    end
  end

  assign bus.led9            = sens_filt[2];
  assign bus.led8            = sens_filt[1];
  assign bus.led7            = sens_filt[0];
  assign bus.bomba           = bomba_reg;
  assign bus.erro_sensor     = erro_reg;
  assign bus.fim_ciclo       = fim_reg;
  assign bus.estado          = state_reg;
  assign bus.contador_falhas = falhas_reg;

endmodule

// File: tb/tb_supervisor_bomba.sv
// Directed bench for supervisor_bomba with default timing parameters (4 / 8 / 200).
module tb_supervisor_bomba;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;
  int   exp_cnt;

  supervisor_bomba_if bus();

  supervisor_bomba dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.chaves_sensores = 3'b000;
    bus.liga            = 1'b0;
    bus.desliga         = 1'b0;
    bus.reconhece       = 1'b0;
    tick(2);
    chk("rst_estado", 32'(bus.estado), 0);
    chk("rst_bomba", 32'(bus.bomba), 0);
    chk("rst_erro", 32'(bus.erro_sensor), 0);
    chk("rst_fim", 32'(bus.fim_ciclo), 0);
    chk("rst_cnt", 32'(bus.contador_falhas), 0);
    chk("rst_leds", 32'({bus.led9, bus.led8, bus.led7}), 0);

    rst_n               = 1'b1;
    bus.chaves_sensores = 3'b111;
    tick(10);
    chk("leds_up", 32'({bus.led9, bus.led8, bus.led7}), 7);
    chk("idle", 32'(bus.estado), 0);

    // Start: VERIFICA for 8 cycles, then BOMBEANDO for 200 cycles.
    bus.liga = 1'b1;
    tick(1);
    bus.liga = 1'b0;
    chk("verif_entry", 32'(bus.estado), 1);
    tick(7);
    chk("verif_last", 32'(bus.estado), 1);
    chk("verif_nobomba", 32'(bus.bomba), 0);
    tick(1);
    chk("pump_entry", 32'(bus.estado), 2);
    chk("pump_bomba", 32'(bus.bomba), 1);
    tick(199);
    chk("pump_last", 32'(bus.bomba), 1);
    chk("pump_last_fim", 32'(bus.fim_ciclo), 0);
    tick(1);
    chk("tmo_estado", 32'(bus.estado), 0);
    chk("tmo_bomba", 32'(bus.bomba), 0);
    chk("tmo_fim", 32'(bus.fim_ciclo), 1);
    tick(1);
    chk("tmo_fim_once", 32'(bus.fim_ciclo), 0);

    // Glitch of 2 cycles is filtered; a 5+ cycle drop reaches FALHA at the 5th edge.
    bus.liga = 1'b1;
    tick(1);
    bus.liga = 1'b0;
    tick(8);
    chk("pump2", 32'(bus.estado), 2);
    bus.chaves_sensores = 3'b101;
    tick(2);
    bus.chaves_sensores = 3'b111;
    tick(5);
    chk("glitch_estado", 32'(bus.estado), 2);
    chk("glitch_led8", 32'(bus.led8), 1);
    bus.chaves_sensores = 3'b101;
    tick(4);
    chk("drop_led8", 32'(bus.led8), 0);
    chk("drop_edge4", 32'(bus.estado), 2);
    tick(1);
    chk("falha_estado", 32'(bus.estado), 3);
    chk("falha_erro", 32'(bus.erro_sensor), 1);
    chk("falha_bomba", 32'(bus.bomba), 0);
    chk("falha_cnt", 32'(bus.contador_falhas), 1);

    // Acknowledge ignored while the sensor is still bad.
    bus.reconhece = 1'b1;
    tick(1);
    bus.reconhece = 1'b0;
    chk("ack_bad", 32'(bus.estado), 3);
    bus.chaves_sensores = 3'b111;
    tick(4);
    chk("restore_led8", 32'(bus.led8), 1);
    bus.reconhece = 1'b1;
    tick(1);
    bus.reconhece = 1'b0;
    chk("ack_ok", 32'(bus.estado), 0);
    chk("ack_erro", 32'(bus.erro_sensor), 0);

    // desliga dominates liga in OCIOSO; desliga aborts VERIFICA.
    bus.liga    = 1'b1;
    bus.desliga = 1'b1;
    tick(1);
    bus.liga    = 1'b0;
    bus.desliga = 1'b0;
    chk("liga_desliga", 32'(bus.estado), 0);
    bus.liga = 1'b1;
    tick(1);
    bus.liga = 1'b0;
    chk("verif3", 32'(bus.estado), 1);
    tick(3);
    bus.desliga = 1'b1;
    tick(1);
    bus.desliga = 1'b0;
    chk("verif_abort", 32'(bus.estado), 0);
    chk("verif_abort_bomba", 32'(bus.bomba), 0);

    // Filtered SP drop and desliga seen at the same edge: fault wins.
    bus.liga = 1'b1;
    tick(1);
    bus.liga = 1'b0;
    tick(8);
    chk("pump3", 32'(bus.estado), 2);
    bus.chaves_sensores = 3'b011;
    tick(4);
    chk("pump3_hold", 32'(bus.estado), 2);
    bus.desliga = 1'b1;
    tick(1);
    bus.desliga = 1'b0;
    chk("fault_wins", 32'(bus.estado), 3);
    chk("fault_wins_cnt", 32'(bus.contador_falhas), 2);
    bus.chaves_sensores = 3'b111;
    tick(4);
    bus.reconhece = 1'b1;
    tick(1);
    bus.reconhece = 1'b0;
    chk("recover3", 32'(bus.estado), 0);

    // 260 more fault entries through VERIFICA; the counter saturates at 255.
    exp_cnt = 2;
    for (int i = 0; i < 260; i++) begin
      bus.chaves_sensores = 3'b110;
      bus.liga            = 1'b1;
      tick(1);
      bus.liga = 1'b0;
      tick(4);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("sat_falha", 32'(bus.estado), 3);
      chk("sat_cnt", 32'(bus.contador_falhas), 32'(exp_cnt));
      bus.chaves_sensores = 3'b111;
      tick(4);
      bus.reconhece = 1'b1;
      tick(1);
      bus.reconhece = 1'b0;
    end
    chk("sat_final", 32'(bus.contador_falhas), 255);
    chk("sat_idle", 32'(bus.estado), 0);

    // Reset in the middle of pumping.
    bus.liga = 1'b1;
    tick(1);
    bus.liga = 1'b0;
    tick(8);
    chk("pump4", 32'(bus.estado), 2);
    tick(10);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mrst_bomba", 32'(bus.bomba), 0);
    chk("mrst_estado", 32'(bus.estado), 0);
    chk("mrst_leds", 32'({bus.led9, bus.led8, bus.led7}), 0);
    chk("mrst_cnt", 32'(bus.contador_falhas), 0);
    chk("mrst_erro", 32'(bus.erro_sensor), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
